ovl_delta_cfg_ctrl: RTL
=======================

// Module: ovl_delta_cfg_ctrl
// PURPOSE
//  Configuration sequencer for a bank of NUM_CHK wrapped delta checkers.
//  Accepts min/max writes over a valid/ready port into per-checker shadow registers.
//  A commit applies all pending shadows atomically to the active limits driven into the checkers.
//  Drives each checker's prevConfigInvalid so firings are masked across reset and reconfiguration.
// PARAMETERS
//  NUM_CHK      4  number of checkers served
//  IDX_W        2  checker index width; must satisfy 2**IDX_W >= NUM_CHK
//  limit_width  8  width of each min/max limit
//  SETTLE       2  mask cycles after a commit; legal range 1..15
// PORTS
//  clk          in   1                    clock
//  rst          in   1                    synchronous, active-high reset
//  cfg_valid    in   1                    write request
//  cfg_ready    out  1                    write accepted when cfg_valid & cfg_ready
//  cfg_idx      in   IDX_W                target checker
//  cfg_min      in   limit_width          new min
//  cfg_max      in   limit_width          new max
//  cfg_commit   in   1                    single-cycle strobe: apply pending shadows
//  cfg_err      out  1                    1-cycle pulse: write rejected
//  busy         out  1                    commit/settle in progress
//  min_o        out  NUM_CHK*limit_width  active mins; checker i in slice [i*limit_width +: limit_width]
//  max_o        out  NUM_CHK*limit_width  active maxes; same slicing as min_o
//  cfg_invalid  out  NUM_CHK              per-checker prevConfigInvalid
// BEHAVIOUR
//  Reset values
//   - min_o = 0; max_o = all ones; shadows = same values; dirty = 0.
//   - cfg_invalid = all ones; cfg_err = 0; busy = 0; state = IDLE.
//   - A checker's cfg_invalid stays high after reset until that checker's first commit completes.
//  FSM
//   - IDLE   : cfg_ready = 1. Go to COMMIT on cfg_commit when any dirty bit is set,
//              or when a write in the same cycle sets one.
//   - COMMIT : one cycle. For every dirty i: copy shadow[i] to active[i], set cfg_invalid[i],
//              clear dirty[i]. Load settle counter with SETTLE-1. Go to SETTLE.
//   - SETTLE : decrement counter; at 0, clear cfg_invalid for checkers committed this pass,
//              then go to IDLE.
//   - cfg_ready = 0 in COMMIT and SETTLE; busy = 1 in COMMIT and SETTLE.
//  Writes
//   - On handshake, store {cfg_min, cfg_max} into shadow[cfg_idx] and set dirty[cfg_idx].
//   - Reject, with no state change and cfg_err pulsed the next cycle, if
//     cfg_min > cfg_max (unsigned) or cfg_idx >= NUM_CHK.
//   - Repeated writes to the same idx before a commit: last accepted write wins.
//  Commit
//   - cfg_commit with no dirty bits and no same-cycle accepted write: ignored; no mask pulse.
//   - Write and cfg_commit in the same cycle: the write is accepted and included in that commit.
//   - cfg_commit during COMMIT or SETTLE: dropped, not queued.
//   - Active limits change only in COMMIT; outputs are registered, so new limits are visible
//     the cycle after COMMIT.
//   - cfg_invalid for committed checkers is high from the cycle after COMMIT for
//     SETTLE+1 cycles total.
//   - Uncommitted checkers keep their current cfg_invalid value.
//  Reset mid-operation: rst in any state returns all registers to reset values on that edge;
//   pending shadows are discarded.
// TESTING
//  1. Reset 3 cycles -> min_o=0, max_o=all ones, cfg_invalid=4'b1111, cfg_ready=1, busy=0.
//  2. Write idx1 min=3 max=9, commit -> slice1 = 3/9 one cycle after COMMIT;
//     cfg_invalid[1] high exactly 3 cycles (SETTLE=2), then 0; cfg_invalid[0,2,3] stay 1.
//  3. Write idx2 min=10 max=4 -> cfg_err pulses once, dirty unchanged; then commit -> ignored, busy stays 0.
//  4. Write idx0 5/6 and cfg_commit in the same cycle -> idx0 committed;
//     cfg_ready=0 for COMMIT+SETTLE (3 cycles).
//  5. Two writes to idx3 (1/2 then 7/8), commit -> slice3 = 7/8;
//     cfg_commit strobed during SETTLE -> no second pass.
//  6. Assert rst during SETTLE -> next cycle all outputs at reset values, cfg_invalid=4'b1111.

Source files
------------

// File: rtl/ovl_delta_cfg_ctrl_if.sv
// Configuration port of the delta-checker config sequencer: write handshake, commit strobe,
// status and the active limit / prevConfigInvalid bundle driven into the checkers.
interface ovl_delta_cfg_ctrl_if #(
  parameter int NUM_CHK     = 4,
  parameter int IDX_W       = 2,
  parameter int limit_width = 8
);
  logic                           cfg_valid;
  logic                           cfg_ready;
  logic [IDX_W-1:0]               cfg_idx;
  logic [limit_width-1:0]         cfg_min;
  logic [limit_width-1:0]         cfg_max;
  logic                           cfg_commit;
  logic                           cfg_err;
  logic                           busy;
  logic [NUM_CHK*limit_width-1:0] min_o;
  logic [NUM_CHK*limit_width-1:0] max_o;
  logic [NUM_CHK-1:0]             cfg_invalid;

  modport master (
    output cfg_valid, cfg_idx, cfg_min, cfg_max, cfg_commit,
    input  cfg_ready, cfg_err, busy, min_o, max_o, cfg_invalid
  );

  modport slave (
    input  cfg_valid, cfg_idx, cfg_min, cfg_max, cfg_commit,
    output cfg_ready, cfg_err, busy, min_o, max_o, cfg_invalid
  );
endinterface

// File: rtl/ovl_delta_cfg_ctrl.sv
// Shadow/commit config sequencer for NUM_CHK delta checkers; limits update the cycle after COMMIT.
// Writes are only accepted in IDLE (cfg_ready low through COMMIT+SETTLE); commits while busy are dropped.
module ovl_delta_cfg_ctrl #(
  parameter int NUM_CHK     = 4,
  parameter int IDX_W       = 2,
  parameter int limit_width = 8,
  parameter int SETTLE      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  ovl_delta_cfg_ctrl_if.slave   cfg
);

  typedef enum logic [1:0] {IDLE, COMMIT, SETTLE_ST} state_t;

  state_t                         state;
  logic [limit_width-1:0]         sh_min [NUM_CHK];
  logic [limit_width-1:0]         sh_max [NUM_CHK];
  logic [NUM_CHK-1:0]             dirty;
  logic [NUM_CHK-1:0]             pass_mask;
  logic                           clr_pend;
  logic [3:0]                     cnt;

  logic                           ready_q;
  logic                           busy_q;
  logic                           err_q;
  logic [NUM_CHK*limit_width-1:0] min_q;
  logic [NUM_CHK*limit_width-1:0] max_q;
  logic [NUM_CHK-1:0]             inv_q;

  logic                           wr_hs;
  logic                           wr_bad;
  logic [NUM_CHK-1:0]             wr_sel;
  logic                           commit_go;

  assign wr_hs  = cfg.cfg_valid & ready_q;
  assign wr_bad = (cfg.cfg_min > cfg.cfg_max) ||
                  ({1'b0, cfg.cfg_idx} >= (IDX_W+1)'(NUM_CHK));

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_CHK; i++) begin
      wr_sel[i] = wr_hs && !wr_bad && (cfg.cfg_idx == IDX_W'(i));
    end
  end

  // A write landing in the same cycle as the strobe counts towards "something to commit".
  assign commit_go = (state == IDLE) && cfg.cfg_commit && ((dirty | wr_sel) != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      dirty     <= '0;
      pass_mask <= '0;
      clr_pend  <= 1'b0;
      cnt       <= '0;
      min_q     <= '0;
      max_q     <= '1;
      inv_q     <= '1;
      for (int i = 0; i < NUM_CHK; i++) begin
        sh_min[i] <= '0;
        sh_max[i] <= '1;
      end
    end else begin
      err_q <= wr_hs & wr_bad;
      dirty <= dirty | wr_sel;
      for (int i = 0; i < NUM_CHK; i++) begin
        if (wr_sel[i]) begin
          sh_min[i] <= cfg.cfg_min;
          sh_max[i] <= cfg.cfg_max;
        end
      end

      // Unmask one cycle after SETTLE ends so the mask spans SETTLE+1 cycles.
      if (clr_pend) begin
        inv_q    <= inv_q & ~pass_mask;
        clr_pend <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (commit_go) begin
            state   <= COMMIT;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        COMMIT: begin
          for (int i = 0; i < NUM_CHK; i++) begin
            if (dirty[i]) begin
              min_q[i*limit_width +: limit_width] <= sh_min[i];
              max_q[i*limit_width +: limit_width] <= sh_max[i];
            end
          end
          inv_q     <= inv_q | dirty;
          pass_mask <= dirty;
          dirty     <= '0;
          cnt       <= 4'(SETTLE - 1);
          state     <= SETTLE_ST;
        end
        SETTLE_ST: begin
          if (cnt == 4'd0) begin
            state    <= IDLE;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            clr_pend <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cfg.cfg_ready   = ready_q;
  assign cfg.busy        = busy_q;
  assign cfg.cfg_err     = err_q;
  assign cfg.min_o       = min_q;
  assign cfg.max_o       = max_q;
  assign cfg.cfg_invalid = inv_q;

endmodule
